// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: sequences IF/ID/EX/MEM/WB, stretches memory
// states by MEM_LATENCY, counts retired instructions and latches a halt on ecall.
module multicycle_control_fsm #(
    parameter int MEM_LATENCY = 1,
    parameter int WAIT_W      = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             halt_cond,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             pc_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic             is_halted
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);

    state_t            fsm;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_done;
    logic              is_exec;
    logic              halt_req;

    assign wait_done = (wait_cnt == WAIT_LAST);
    assign is_exec   = opcode inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
    assign halt_req  = (opcode == OP_ECALL) && halt_cond;
    assign state     = fsm;

    // Moore decode; reset overrides everything so an aborted instruction writes nothing.
    always_comb begin
        pc_write   = 1'b0;
        pc_source  = 2'd0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        pc_to_reg  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        if (!reset) begin
            case (fsm)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_write = wait_done;
                end
                S_ID: pc_write = !is_exec && !halt_req;
                S_EX: begin
                    case (opcode)
                        OP_R: begin
                            alu_src_a = 1'b1;
                            alu_op    = 2'd2;
                        end
                        OP_IMM: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'd1;
                            alu_op    = 2'd2;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'd1;
                        end
                        OP_BRANCH: begin
                            alu_src_a = 1'b1;
                            alu_op    = 2'd1;
                            pc_write  = 1'b1;
                            pc_source = bcond ? 2'd1 : 2'd0;
                        end
                        OP_JAL, OP_JALR: begin
                            alu_src_a = (opcode == OP_JALR);
                            alu_src_b = 2'd1;
                            pc_source = (opcode == OP_JALR) ? 2'd2 : 2'd1;
                            pc_write  = 1'b1;
                            reg_write = 1'b1;
                            pc_to_reg = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    i_or_d   = 1'b1;
                    mem_read = (opcode == OP_LOAD);
                    if (opcode == OP_STORE && wait_done) begin
                        mem_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opcode == OP_LOAD);
                    pc_write   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Every retirement is marked by exactly one pc_write pulse, so it drives instret.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= S_IF;
            wait_cnt  <= '0;
            instret   <= '0;
            is_halted <= 1'b0;
        end else begin
            if (pc_write) instret <= instret + CNT_W'(1);
            case (fsm)
                S_IF: begin
                    if (wait_done) begin
                        wait_cnt <= '0;
                        fsm      <= S_ID;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_ID: begin
                    if (is_exec) begin
                        fsm <= S_EX;
                    end else if (halt_req) begin
                        fsm       <= S_HALT;
                        is_halted <= 1'b1;
                    end else begin
                        fsm <= S_IF;
                    end
                end
                S_EX: begin
                    case (opcode)
                        OP_R, OP_IMM:      fsm <= S_WB;
                        OP_LOAD, OP_STORE: fsm <= S_MEM;
                        default:           fsm <= S_IF;
                    endcase
                end
                S_MEM: begin
                    if (wait_done) begin
                        wait_cnt <= '0;
                        fsm      <= (opcode == OP_LOAD) ? S_WB : S_IF;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB:    fsm <= S_IF;
                S_HALT:  fsm <= S_HALT;
                default: fsm <= S_IF;
            endcase
        end
    end

endmodule
